forward_scoreboard: RTL and testbench

//  Parametrised forwarding/hazard unit for the pipelined RISC-V core. Keeps its own

---
 rtl/forward_scoreboard_if.sv | 36 +++
 rtl/forward_scoreboard.sv | 102 ++++++++++
 tb/tb_forward_scoreboard.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/forward_scoreboard_if.sv
// Bundle between ID/EX control and the forwarding/hazard unit.
// The master drives issue and operand info; the slave returns selects, stall and statistics.
interface forward_scoreboard_if #(
    parameter int ADDR_W  = 5,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 2,
    parameter int CNT_W   = 16
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    logic                      freeze_i;
    logic                      flush_i;
    logic [ADDR_W-1:0]         issue_rd_i;
    logic                      issue_we_i;
    logic                      issue_ld_i;
    logic [NUM_SRC*ADDR_W-1:0] id_rs_i;
    logic [NUM_SRC-1:0]        id_use_i;
    logic [NUM_SRC*ADDR_W-1:0] ex_rs_i;
    logic [NUM_SRC*SEL_W-1:0]  fwd_sel_o;
    logic                      stall_o;
    logic                      hazard_err_o;
    logic [CNT_W-1:0]          stall_cnt_o;
    logic [CNT_W-1:0]          fwd_cnt_o;

    modport master (
        output freeze_i, flush_i, issue_rd_i, issue_we_i, issue_ld_i,
               id_rs_i, id_use_i, ex_rs_i,
        input  fwd_sel_o, stall_o, hazard_err_o, stall_cnt_o, fwd_cnt_o
    );

    modport slave (
        input  freeze_i, flush_i, issue_rd_i, issue_we_i, issue_ld_i,
               id_rs_i, id_use_i, ex_rs_i,
        output fwd_sel_o, stall_o, hazard_err_o, stall_cnt_o, fwd_cnt_o
    );
endinterface

// File: rtl/forward_scoreboard.sv
// Forwarding/hazard unit: shift-register scoreboard of in-flight destinations (EX onward),
// per-operand forward selects, load-use stall and saturating stall/forward statistics.
module forward_scoreboard #(
    parameter int ADDR_W     = 5,
    parameter int NUM_SRC    = 2,
    parameter int DEPTH      = 2,
    parameter int LOAD_READY = 2,
    parameter int CNT_W      = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    forward_scoreboard_if.slave bus
);
    localparam int SEL_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] rd;
        logic              we;
        logic              ld;
    } slot_t;

    slot_t [DEPTH:0]                r_slot;
    logic                           r_err;
    logic [CNT_W-1:0]               r_stall_cnt;
    logic [CNT_W-1:0]               r_fwd_cnt;

    logic [NUM_SRC-1:0][SEL_W-1:0]  w_sel;
    logic [NUM_SRC-1:0]             w_unready;
    logic [NUM_SRC-1:0]             w_fwd_any;
    logic [NUM_SRC-1:0]             w_src_stall;
    logic                           w_stall;

    function automatic logic writes_reg(input slot_t s, input logic [ADDR_W-1:0] r);
        return s.v && s.we && (s.rd != '0) && (s.rd == r);
    endfunction

    // Scanning oldest to youngest lets the youngest producer overwrite the result.
    // MSB of the result flags that the chosen slot holds a load that is not ready yet.
    function automatic logic [SEL_W:0] pick_fwd(input slot_t [DEPTH:0] s,
                                                input logic [ADDR_W-1:0] r);
        logic [SEL_W:0] res;
        res = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (writes_reg(s[k], r))
                res = {s[k].ld && (k < LOAD_READY), SEL_W'(k)};
        end
        return res;
    endfunction

    function automatic logic load_hit(input slot_t [DEPTH:0] s,
                                      input logic [ADDR_W-1:0] r);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < LOAD_READY - 1; k++) begin
            if (s[k].ld && writes_reg(s[k], r))
                hit = 1'b1;
        end
        return hit;
    endfunction

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [SEL_W:0] w_pick;
        assign w_pick         = pick_fwd(r_slot, bus.ex_rs_i[gi*ADDR_W +: ADDR_W]);
        assign w_sel[gi]      = w_pick[SEL_W-1:0];
        assign w_unready[gi]  = w_pick[SEL_W];
        assign w_fwd_any[gi]  = |w_pick[SEL_W-1:0];
        assign w_src_stall[gi] = bus.id_use_i[gi] &&
                                 load_hit(r_slot, bus.id_rs_i[gi*ADDR_W +: ADDR_W]);
    end

    assign w_stall = |w_src_stall;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_slot      <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else if (!bus.freeze_i) begin
            for (int k = 1; k <= DEPTH; k++)
                r_slot[k] <= r_slot[k-1];
            // A stalled or flushed issue becomes a bubble in EX.
            if (w_stall || bus.flush_i)
                r_slot[0] <= '0;
            else
                r_slot[0] <= {1'b1, bus.issue_rd_i, bus.issue_we_i, bus.issue_ld_i};
            if (|w_unready)
                r_err <= 1'b1;
            if (w_stall && !(&r_stall_cnt))
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            if ((|w_fwd_any) && !(&r_fwd_cnt))
                r_fwd_cnt <= r_fwd_cnt + CNT_W'(1);
        end
    end

    assign bus.fwd_sel_o    = w_sel;
    assign bus.stall_o      = w_stall;
    assign bus.hazard_err_o = r_err;
    assign bus.stall_cnt_o  = r_stall_cnt;
    assign bus.fwd_cnt_o    = r_fwd_cnt;
endmodule

// File: tb/tb_forward_scoreboard.sv
// Directed bench for forward_scoreboard: default instance (DEPTH=2, LOAD_READY=2) and a
// small-counter instance (DEPTH=3, LOAD_READY=3, CNT_W=4).
module tb_forward_scoreboard;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    forward_scoreboard_if #(.ADDR_W(5), .NUM_SRC(2), .DEPTH(2), .CNT_W(16)) bus_a ();
    forward_scoreboard_if #(.ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .CNT_W(4))  bus_b ();

    forward_scoreboard #(.ADDR_W(5), .NUM_SRC(2), .DEPTH(2), .LOAD_READY(2), .CNT_W(16)) u_dut_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    forward_scoreboard #(.ADDR_W(5), .NUM_SRC(2), .DEPTH(3), .LOAD_READY(3), .CNT_W(4)) u_dut_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Inputs for instance A; operand fields are given as (rs1, rs2).
    task automatic set_a(input logic [4:0] rd, input logic we, input logic ld,
                         input logic [4:0] id1, input logic [4:0] id2, input logic [1:0] idu,
                         input logic [4:0] ex1, input logic [4:0] ex2);
        bus_a.issue_rd_i = rd;
        bus_a.issue_we_i = we;
        bus_a.issue_ld_i = ld;
        bus_a.id_rs_i    = {id2, id1};
        bus_a.id_use_i   = idu;
        bus_a.ex_rs_i    = {ex2, ex1};
        #1;
    endtask

    task automatic set_b(input logic [4:0] rd, input logic we, input logic ld,
                         input logic [4:0] id1, input logic [4:0] id2, input logic [1:0] idu,
                         input logic [4:0] ex1, input logic [4:0] ex2);
        bus_b.issue_rd_i = rd;
        bus_b.issue_we_i = we;
        bus_b.issue_ld_i = ld;
        bus_b.id_rs_i    = {id2, id1};
        bus_b.id_use_i   = idu;
        bus_b.ex_rs_i    = {ex2, ex1};
        #1;
    endtask

    initial begin
        bus_a.freeze_i = 1'b0;
        bus_a.flush_i  = 1'b0;
        bus_b.freeze_i = 1'b0;
        bus_b.flush_i  = 1'b0;
        set_b(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0);

        // Reset with random traffic on A
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            bus_a.freeze_i = 1'($urandom);
            bus_a.flush_i  = 1'($urandom);
            set_a(5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom),
                  2'($urandom), 5'($urandom), 5'($urandom));
            tick();
        end
        check_val("rst_sel",   32'(bus_a.fwd_sel_o),    32'h0);
        check_val("rst_stall", 32'(bus_a.stall_o),      32'h0);
        check_val("rst_scnt",  32'(bus_a.stall_cnt_o),  32'h0);
        check_val("rst_fcnt",  32'(bus_a.fwd_cnt_o),    32'h0);
        check_val("rst_err",   32'(bus_a.hazard_err_o), 32'h0);
        bus_a.freeze_i = 1'b0;
        bus_a.flush_i  = 1'b0;
        set_a(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0);
        rst = 1'b1;
        tick();

        // ALU forwarding: add x5 ; sub x6, x5, x5
        set_a(5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0); tick();
        set_a(5'd6, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0); tick();
        set_a(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd5, 5'd5);
        check_val("fwd_b2b", 32'(bus_a.fwd_sel_o), 32'h5);
        tick();
        set_a(5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd5, 5'd6);
        check_val("fwd_gap", 32'(bus_a.fwd_sel_o), 32'h6);
        tick();
        set_a(5'd5, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0); tick();
        set_a(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0); tick();
        set_a(5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 5'd0);
        check_val("fwd_young", 32'(bus_a.fwd_sel_o), 32'h1);
        check_val("fcnt_2",    32'(bus_a.fwd_cnt_o), 32'd2);
        tick();

        // Load-use: lw x7 ; add x8, x1, x7
        set_a(5'd8, 1'b1, 1'b0, 5'd1, 5'd7, 2'b10, 5'd2, 5'd0);
        check_val("lu_sel0",  32'(bus_a.fwd_sel_o), 32'h0);
        check_val("lu_stall", 32'(bus_a.stall_o),   32'h1);
        tick();
        set_a(5'd8, 1'b1, 1'b0, 5'd1, 5'd7, 2'b10, 5'd0, 5'd0);
        check_val("lu_release", 32'(bus_a.stall_o), 32'h0);
        tick();
        set_a(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd1, 5'd7);
        check_val("lu_sel2", 32'(bus_a.fwd_sel_o),    32'h8);
        check_val("lu_scnt", 32'(bus_a.stall_cnt_o),  32'd1);
        check_val("lu_err",  32'(bus_a.hazard_err_o), 32'h0);
        tick();
        set_a(5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0); tick();
        set_a(5'd8, 1'b1, 1'b0, 5'd1, 5'd7, 2'b00, 5'd0, 5'd0);
        check_val("nouse_stall", 32'(bus_a.stall_o), 32'h0);
        tick();
        // Forwarding an unready load from slot 1 must flag a hazard
        set_a(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd7);
        check_val("hz_sel1", 32'(bus_a.fwd_sel_o),   32'h4);
        check_val("hz_scnt", 32'(bus_a.stall_cnt_o), 32'd1);
        tick();
        check_val("hz_err", 32'(bus_a.hazard_err_o), 32'h1);

        // x0 writers and we=0 writers never forward or stall
        set_a(5'd3, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0); tick();
        set_a(5'd3, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0); tick();
        set_a(5'd0, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0); tick();
        set_a(5'd0, 1'b0, 1'b0, 5'd0, 5'd3, 2'b11, 5'd0, 5'd3);
        check_val("x0_sel",   32'(bus_a.fwd_sel_o), 32'h0);
        check_val("x0_stall", 32'(bus_a.stall_o),   32'h0);
        check_val("x0_fcnt",  32'(bus_a.fwd_cnt_o), 32'd5);
        tick();

        // Freeze holds everything, flush bubbles EX
        set_a(5'd9,  1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0); tick();
        set_a(5'd10, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0); tick();
        set_a(5'd9,  1'b1, 1'b0, 5'd0, 5'd0, 2'b00, 5'd9, 5'd9);
        check_val("pre_frz_sel", 32'(bus_a.fwd_sel_o), 32'h5);
        bus_a.freeze_i = 1'b1;
        bus_a.flush_i  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_val("frz_sel",  32'(bus_a.fwd_sel_o), 32'h5);
            check_val("frz_fcnt", 32'(bus_a.fwd_cnt_o), 32'd5);
        end
        bus_a.freeze_i = 1'b0;
        tick();
        bus_a.flush_i = 1'b0;
        set_a(5'd0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00, 5'd9, 5'd9);
        check_val("flush_sel2", 32'(bus_a.fwd_sel_o), 32'hA);
        tick();
        check_val("flush_gone", 32'(bus_a.fwd_sel_o), 32'h0);
        check_val("flush_fcnt", 32'(bus_a.fwd_cnt_o), 32'd7);

        // Reset in the middle of operation
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_val("mrst_fcnt", 32'(bus_a.fwd_cnt_o),    32'h0);
        check_val("mrst_scnt", 32'(bus_a.stall_cnt_o),  32'h0);
        check_val("mrst_err",  32'(bus_a.hazard_err_o), 32'h0);

        // Instance B: two-cycle load-use stall, then counter saturation
        set_b(5'd7, 1'b1, 1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 5'd0); tick();
        set_b(5'd8, 1'b1, 1'b0, 5'd7, 5'd0, 2'b01, 5'd0, 5'd0);
        check_val("b_stall1", 32'(bus_b.stall_o), 32'h1);
        tick();
        check_val("b_stall2", 32'(bus_b.stall_o), 32'h1);
        tick();
        check_val("b_stall3", 32'(bus_b.stall_o),     32'h0);
        check_val("b_scnt2",  32'(bus_b.stall_cnt_o), 32'd2);
        tick();
        set_b(5'd7, 1'b1, 1'b1, 5'd7, 5'd0, 2'b01, 5'd7, 5'd0);
        check_val("b_sel3", 32'(bus_b.fwd_sel_o),    32'h3);
        check_val("b_err",  32'(bus_b.hazard_err_o), 32'h0);
        tick();
        set_b(5'd7, 1'b1, 1'b1, 5'd7, 5'd0, 2'b01, 5'd0, 5'd0);
        for (int c = 0; c < 29; c++) tick();
        check_val("b_scnt_sat", 32'(bus_b.stall_cnt_o), 32'd15);
        check_val("b_fcnt",     32'(bus_b.fwd_cnt_o),   32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
